// File: rtl/serv_ldst_buf_if.sv
// Bus and serial-control bundle between the SERV core control and the
// load/store buffer.
interface serv_ldst_buf_if;
  logic        i_en;
  logic        i_d;
  logic        i_store;
  logic        i_load;
  logic [31:0] i_dat;
  logic [1:0]  i_lsb;
  logic        i_half;
  logic        i_word;
  logic        i_sh_start;
  logic        i_sh_dec;
  logic        o_q;
  logic [1:0]  o_bytecnt;
  logic        o_cnt_done;
  logic        o_sh_done;
  logic [31:0] o_wb_dat;

  modport master (
    output i_en, i_d, i_store, i_load, i_dat, i_lsb, i_half, i_word,
           i_sh_start, i_sh_dec,
    input  o_q, o_bytecnt, o_cnt_done, o_sh_done, o_wb_dat
  );

  modport slave (
    input  i_en, i_d, i_store, i_load, i_dat, i_lsb, i_half, i_word,
           i_sh_start, i_sh_dec,
    output o_q, o_bytecnt, o_cnt_done, o_sh_done, o_wb_dat
  );
endinterface

// File: rtl/serv_ldst_buf.sv
// Serial load/store data buffer, bit/byte sequencer and shift-amount counter
// feeding serv_mem_if.
module serv_ldst_buf #(
  parameter int W = 1
) (
  input logic            i_clk,
  input logic            i_rst,
  serv_ldst_buf_if.slave bus
);

  generate
    if (W != 1) begin : g_bad_width
      $error("serv_ldst_buf: only W=1 is supported");
    end
  endgenerate

  logic [31:0] dat;
  logic [4:0]  cnt;
  logic [5:0]  shcnt;

  // A load realigns the addressed lane to bit 0; a load beats a same-cycle
  // shift, while cnt keeps counting enables regardless.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dat   <= 32'd0;
      cnt   <= 5'd0;
      shcnt <= 6'd0;
    end else begin
      if (bus.i_en)
        cnt <= cnt + 5'd1;

      if (bus.i_load)
        dat <= bus.i_dat >> {bus.i_lsb, 3'b000};
      else if (bus.i_en)
        dat <= {bus.i_store & bus.i_d, dat[31:1]};

      // Bit 5 acts as a sticky underflow flag once the count passes zero.
      if (bus.i_sh_start)
        shcnt <= {1'b0, dat[4:0]};
      else if (bus.i_sh_dec && !shcnt[5])
        shcnt <= shcnt - 6'd1;
    end
  end

  always_comb begin
    bus.o_wb_dat = {4{dat[7:0]}};
    if (bus.i_word)
      bus.o_wb_dat = dat;
    else if (bus.i_half)
      bus.o_wb_dat = {2{dat[15:0]}};
  end

  assign bus.o_q        = dat[0];
  assign bus.o_bytecnt  = cnt[4:3];
  assign bus.o_cnt_done = bus.i_en & (cnt == 5'd31);
  assign bus.o_sh_done  = shcnt[5];

endmodule

// File: doc/serv_ldst_buf.md
Name: serv_ldst_buf

Overview:
- Serial load/store data buffer and bit/byte sequencer. It sits directly upstream of the memory-interface stage (serv_mem_if).
- Holds the 32-bit data-bus word. It shifts load data out one bit per enabled cycle as o_q, which drives mem_if i_bufreg2_q, and generates o_bytecnt for mem_if i_bytecnt.
- Serially collects rs2 for stores and presents lane-replicated write data to the data bus.
- Also provides the shift-amount down-counter used by shift instructions.

Parameters:
- W, 1, serial datapath width. Only 1 is supported; any other value is an elaboration error.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  serial cycle enable; one bit processed per asserted cycle
- i_d  input  1  serial rs2 bit shifted in during stores
- i_store  input  1  1 = shift i_d in at the top; 0 = shift 0 in at the top
- i_load  input  1  data-bus ack of a load; parallel-load i_dat
- i_dat  input  32  data-bus read data
- i_lsb  input  2  byte offset of the access
- i_half  input  1  halfword access
- i_word  input  1  word access
- i_sh_start  input  1  load the shift counter from dat[4:0]
- i_sh_dec  input  1  decrement the shift counter
- o_q  output  1  current serial bit = dat[0]
- o_bytecnt  output  2  = cnt[4:3]
- o_cnt_done  output  1  i_en & (cnt == 31)
- o_sh_done  output  1  = shcnt[5]
- o_wb_dat  output  32  store data, lane-replicated

Behaviour:
- State registers: dat[31:0], cnt[4:0], shcnt[5:0].
- Reset (asynchronous, on i_rst high): dat=0, cnt=0, shcnt=0, held while i_rst is high. Resulting outputs: o_q=0, o_bytecnt=0, o_cnt_done=0, o_sh_done=0, o_wb_dat=0.
- Reset mid-operation aborts the operation immediately. There is no resume.
- cnt: increments by 1 on every i_en cycle and wraps 31->0. It is unaffected by i_load and by the shift-counter controls.
- dat update, priority highest first, one action per cycle:
  1. i_load: dat <= i_dat >> (8*i_lsb), logical shift with zero fill. The addressed byte/halfword lands at dat[7:0]/dat[15:0].
  2. i_en: dat <= {i_store ? i_d : 1'b0, dat[31:1]}.
  3. Otherwise dat holds.
- i_load and i_en in the same cycle: load wins for dat; cnt still increments.
- Load path:
  - One cycle after i_load, o_q = the LSB of the addressed datum.
  - Successive i_en cycles present bits 1, 2, ... with single-cycle latency.
  - Sign extension is done downstream; this block zero-fills.
- Store path: after 32 i_en cycles with i_store=1, dat equals rs2 with bit 0 first in, i.e. i_d of the first cycle ends at dat[0].
- o_wb_dat (combinational from dat):
  - word: dat
  - half: {2{dat[15:0]}}
  - byte (neither i_word nor i_half): {4{dat[7:0]}}
  - i_word takes precedence over i_half.
- Shift counter:
  - i_sh_start: shcnt <= {1'b0, dat[4:0]}. Takes priority over i_sh_dec in the same cycle.
  - i_sh_dec with shcnt[5]==0: shcnt <= shcnt - 1.
  - i_sh_dec with shcnt[5]==1: hold (underflow is sticky).
  - o_sh_done rises after exactly shamt+1 decrements and stays high until the next i_sh_start or reset.
  - The shift counter is independent of dat shifting; i_sh_start samples dat before any same-cycle dat update.
- Boundaries:
  - cnt wraps without a flag other than o_cnt_done. o_cnt_done is combinational and valid only in the cycle i_en is high at cnt=31.
  - i_lsb=3 with i_half or i_word still applies the shift. Misalignment is flagged downstream and not blocked here.
- All outputs are pure functions of registers, except o_cnt_done (depends on i_en) and o_wb_dat (depends on i_half/i_word).

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle with dat loaded 0xFFFFFFFF -> o_q=0, o_wb_dat=0, o_bytecnt=0 immediately; all stay 0 until the first enable after release.
- Byte load: i_dat=0x12345678, i_lsb=2, i_load=1; then 8 i_en cycles -> o_q sequence (LSB first) = 0x34 bits 0,0,1,0,1,1,0,0; o_bytecnt 0 throughout; cnt=8 after.
- Sequencer: 32 consecutive i_en -> o_bytecnt steps 0,1,2,3 every 8 cycles; o_cnt_done high only on the 32nd; cnt returns to 0 on the 33rd edge.
- Store: shift rs2=0xA5C3_0F81 LSB first with i_store=1 over 32 cycles -> dat=0xA5C30F81. i_word -> o_wb_dat=0xA5C30F81; i_half -> 0x0F810F81; byte -> 0x81818181.
- Shift count: dat[4:0]=3, i_sh_start, then i_sh_dec x4 -> o_sh_done low after dec 1-3, high after dec 4, stays high through 2 further i_sh_dec; next i_sh_start with dat[4:0]=0 clears it, one dec sets it.
- Collision: i_load and i_en together with i_dat=0x1 -> dat=0x1 (load wins), cnt increments; i_sh_start and i_sh_dec together -> load wins, no decrement.
